fifo_sync_param: RTL and testbench

Parametrised single-clock synchronous FIFO; the next generation of the fix_parser message-buffering FIFO, with the RAM and control folded into one block. It adds true full/empty at depth 2^ADDR_WIDTH, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between the byte/field front end and the parser core, wherever a clocked elastic buffer is needed.

---
 rtl/fifo_sync_param.sv | 114 +++++++++++
 tb/tb_fifo_sync_param.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_SYNC_PARAM_FWFT_EN for first-word fall-through output; otherwise data_o is a registered pop.
module fifo_sync_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rd_en_i,
    input  logic                  err_clr_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Flags decode only from registered count: no request-to-output paths.
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == DEPTH_C);
    assign almost_full_o  = (count_q >= AFULL_C);
    assign almost_empty_o = (count_q <= AEMPTY_C);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    always_comb begin
        wr_acc   = wr_en_i && !full_o;
        rd_acc   = rd_en_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A fresh error outranks a same-cycle clear.
        overflow_d  = (overflow_q && !err_clr_i) || (wr_en_i && full_o);
        underflow_d = (underflow_q && !err_clr_i) || (rd_en_i && empty_o);
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_SYNC_PARAM_FWFT_EN
    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = !empty_o;
`else
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (rd_acc) begin
            data_d  = mem_q[rd_ptr_q];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at DEPTH 4, AFULL 3, AEMPTY 1.
module tb_fifo_sync_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en_i, rd_en_i, err_clr_i;
    logic [7:0] data_i, data_o;
    logic       valid_o, empty_o, full_o, almost_full_o, almost_empty_o;
    logic [2:0] count_o;
    logic       overflow_o, underflow_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .data_i(data_i),
        .rd_en_i(rd_en_i), .err_clr_i(err_clr_i), .data_o(data_o),
        .valid_o(valid_o), .empty_o(empty_o), .full_o(full_o),
        .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
        .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        logic [2:0] cnt;
        logic       vld;
        logic [7:0] dout;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs [64];
    int   nvec = 0;

    task automatic add(input logic wr, input logic [7:0] din, input logic rd, input logic clr,
                       input logic [2:0] cnt, input logic vld, input logic [7:0] dout,
                       input logic ovf, input logic unf);
        vecs[nvec] = '{wr, din, rd, clr, cnt, vld, dout, ovf, unf};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
        wr_en_i = wr; data_i = din; rd_en_i = rd; err_clr_i = clr;
        @(posedge clk);
        #1;
        wr_en_i = 1'b0; rd_en_i = 1'b0; err_clr_i = 1'b0;
    endtask

    // Flags expected from a given occupancy with DEPTH 4, AFULL 3, AEMPTY 1.
    task automatic chk_flags(input string tag, input logic [2:0] cnt);
        chk({tag, " count"},  32'(count_o),        32'(cnt));
        chk({tag, " empty"},  32'(empty_o),        32'(cnt == 3'd0));
        chk({tag, " full"},   32'(full_o),         32'(cnt == 3'd4));
        chk({tag, " afull"},  32'(almost_full_o),  32'(cnt >= 3'd3));
        chk({tag, " aempty"}, 32'(almost_empty_o), 32'(cnt <= 3'd1));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; wr_en_i = 1'b1; rd_en_i = 1'b1; err_clr_i = 1'b0; data_i = 8'hEE;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
    endtask

    initial begin
        do_reset(2);
        chk_flags("reset", 3'd0);
        chk("reset valid", 32'(valid_o), 32'd0);
        chk("reset ovf", 32'(overflow_o), 32'd0);
        chk("reset unf", 32'(underflow_o), 32'd0);
`ifdef FIFO_SYNC_PARAM_FWFT_EN
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        $display("fwft write a5: data=%02h valid=%0b", data_o, valid_o);
        chk("fwft data", 32'(data_o), 32'hA5);
        chk("fwft valid", 32'(valid_o), 32'd1);
        chk_flags("fwft w", 3'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        $display("fwft pop: valid=%0b empty=%0b", valid_o, empty_o);
        chk("fwft pop valid", 32'(valid_o), 32'd0);
        chk_flags("fwft pop", 3'd0);
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        drive(1'b1, 8'h4D, 1'b0, 1'b0);
        chk("fwft head", 32'(data_o), 32'h3C);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        $display("fwft second: data=%02h valid=%0b", data_o, valid_o);
        chk("fwft next", 32'(data_o), 32'h4D);
        chk("fwft next valid", 32'(valid_o), 32'd1);
`else
        chk("reset data", 32'(data_o), 32'd0);
        //   wr  din    rd  clr  cnt  vld dout  ovf unf
        add(1, 8'h11, 0, 0, 3'd1, 0, 8'h00, 0, 0);
        add(1, 8'h22, 0, 0, 3'd2, 0, 8'h00, 0, 0);
        add(1, 8'h33, 0, 0, 3'd3, 0, 8'h00, 0, 0);
        add(1, 8'h44, 0, 0, 3'd4, 0, 8'h00, 0, 0);
        add(1, 8'h55, 1, 0, 3'd3, 1, 8'h11, 1, 0);
        add(0, 8'h00, 0, 0, 3'd3, 0, 8'h00, 1, 0);
        add(0, 8'h00, 0, 1, 3'd3, 0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 0, 3'd2, 1, 8'h22, 0, 0);
        add(0, 8'h00, 1, 0, 3'd1, 1, 8'h33, 0, 0);
        add(0, 8'h00, 1, 0, 3'd0, 1, 8'h44, 0, 0);
        add(0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0, 1);
        add(0, 8'h00, 1, 1, 3'd0, 0, 8'h00, 0, 1);
        add(0, 8'h00, 0, 1, 3'd0, 0, 8'h00, 0, 0);
        add(1, 8'hA0, 0, 0, 3'd1, 0, 8'h00, 0, 0);
        add(1, 8'hA1, 0, 0, 3'd2, 0, 8'h00, 0, 0);
        add(1, 8'h00, 1, 0, 3'd2, 1, 8'hA0, 0, 0);
        add(1, 8'h01, 1, 0, 3'd2, 1, 8'hA1, 0, 0);
        for (int i = 2; i < 10; i++)
            add(1, 8'(i), 1, 0, 3'd2, 1, 8'(i - 2), 0, 0);
        add(0, 8'h00, 1, 0, 3'd1, 1, 8'h08, 0, 0);
        add(0, 8'h00, 1, 0, 3'd0, 1, 8'h09, 0, 0);
        add(1, 8'h5A, 1, 0, 3'd1, 0, 8'h00, 0, 1);
        add(0, 8'h00, 0, 1, 3'd1, 0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 0, 3'd0, 1, 8'h5A, 0, 0);

        for (int v = 0; v < nvec; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            drive(vecs[v].wr, vecs[v].din, vecs[v].rd, vecs[v].clr);
            $display("%s wr=%0b din=%02h rd=%0b clr=%0b -> cnt=%0d vld=%0b dout=%02h ovf=%0b unf=%0b",
                     tag, vecs[v].wr, vecs[v].din, vecs[v].rd, vecs[v].clr,
                     count_o, valid_o, data_o, overflow_o, underflow_o);
            chk_flags(tag, vecs[v].cnt);
            chk({tag, " valid"}, 32'(valid_o), 32'(vecs[v].vld));
            if (vecs[v].vld) chk({tag, " data"}, 32'(data_o), 32'(vecs[v].dout));
            chk({tag, " ovf"}, 32'(overflow_o), 32'(vecs[v].ovf));
            chk({tag, " unf"}, 32'(underflow_o), 32'(vecs[v].unf));
        end

        // Mid-operation reset discards content and the popped word.
        drive(1'b1, 8'h61, 1'b0, 1'b0);
        drive(1'b1, 8'h62, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        do_reset(1);
        $display("mid reset: cnt=%0d vld=%0b dout=%02h", count_o, valid_o, data_o);
        chk_flags("mid rst", 3'd0);
        chk("mid rst valid", 32'(valid_o), 32'd0);
        chk("mid rst data", 32'(data_o), 32'd0);
        chk("mid rst ovf", 32'(overflow_o), 32'd0);
        chk("mid rst unf", 32'(underflow_o), 32'd0);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        $display("post reset pop: dout=%02h vld=%0b", data_o, valid_o);
        chk("post rst data", 32'(data_o), 32'h77);
        chk("post rst valid", 32'(valid_o), 32'd1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
